// File: rtl/bc_stage_if_prefetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channels,
// the redirect input and the decode-side valid/ready output.
interface bc_stage_if_prefetch_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]  o_imem_raddr;
    logic                   o_imem_raddr_valid;
    logic                   i_imem_raddr_ready;
    logic [INSTR_WIDTH-1:0] i_imem_rdata;
    logic                   i_imem_rdata_valid;
    logic                   o_imem_rdata_ready;
    logic                   i_redirect;
    logic [ADDR_WIDTH-1:0]  i_redirect_pc;
    logic                   o_instr_valid;
    logic                   i_instr_ready;
    logic [INSTR_WIDTH-1:0] o_instr;
    logic [ADDR_WIDTH-1:0]  o_instr_pc;

    // The fetch stage is the master; memory and decode sit on the slave side.
    modport master (
        output o_imem_raddr, o_imem_raddr_valid, o_imem_rdata_ready,
        output o_instr_valid, o_instr, o_instr_pc,
        input  i_imem_raddr_ready, i_imem_rdata, i_imem_rdata_valid,
        input  i_redirect, i_redirect_pc, i_instr_ready
    );

    modport slave (
        input  o_imem_raddr, o_imem_raddr_valid, o_imem_rdata_ready,
        input  o_instr_valid, o_instr, o_instr_pc,
        output i_imem_raddr_ready, i_imem_rdata, i_imem_rdata_valid,
        output i_redirect, i_redirect_pc, i_instr_ready
    );
endinterface

// File: rtl/bc_stage_if_prefetch.sv
// Instruction-fetch stage: credit-limited sequential fetch into a show-ahead
// prefetch FIFO, with redirect that squashes buffered and in-flight work.
module bc_stage_if_prefetch #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    FIFO_DEPTH  = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    bc_stage_if_prefetch_if.master bus
);
    localparam int                    CW      = $clog2(FIFO_DEPTH + 1);
    localparam int                    PW      = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(INSTR_WIDTH / 8);
    localparam logic [CW:0]           DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] fetch_pc_reg, fetch_pc_next;
    logic [ADDR_WIDTH-1:0] ret_pc_reg, ret_pc_next;
    logic [CW-1:0]         outstanding_reg, outstanding_next;
    logic [CW-1:0]         drop_reg, drop_next;
    logic [CW-1:0]         count_reg, count_next;
    logic [PW-1:0]         wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]         rd_ptr_reg, rd_ptr_next;

    logic [CW:0] credit_sum;
    logic        credit_ok;
    logic        req_valid;
    logic        issue;
    logic        rsp;
    logic        rsp_drop;
    logic        push;
    logic        pop;
    logic        fifo_empty;

    logic [INSTR_WIDTH-1:0] entry_instr [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]  entry_pc    [FIFO_DEPTH];

    // Handshake qualification; one extra bit keeps the credit sum from wrapping.
    always_comb begin
        credit_sum = {1'b0, outstanding_reg} + {1'b0, count_reg};
        credit_ok  = credit_sum < DEPTH_W;
        req_valid  = i_rstn & ~bus.i_redirect & credit_ok;
        issue      = req_valid & bus.i_imem_raddr_ready;
        rsp        = bus.i_imem_rdata_valid & (outstanding_reg != '0);
        rsp_drop   = rsp & (drop_reg != '0);
        push       = rsp & ~rsp_drop & ~bus.i_redirect;
        fifo_empty = (count_reg == '0);
        pop        = ~fifo_empty & bus.i_instr_ready & ~bus.i_redirect;
    end

    always_comb begin
        outstanding_next = outstanding_reg + CW'(issue) - CW'(rsp);
        fetch_pc_next    = issue ? fetch_pc_reg + PC_STEP : fetch_pc_reg;
        ret_pc_next      = push ? ret_pc_reg + PC_STEP : ret_pc_reg;
        drop_next        = drop_reg - CW'(rsp_drop);
        count_next       = count_reg + CW'(push) - CW'(pop);
        wr_ptr_next      = wr_ptr_reg + PW'(push);
        rd_ptr_next      = rd_ptr_reg + PW'(pop);
        // Everything still in flight after this cycle's accounting becomes stale.
        if (bus.i_redirect) begin
            fetch_pc_next = bus.i_redirect_pc;
            ret_pc_next   = bus.i_redirect_pc;
            drop_next     = outstanding_next;
            count_next    = '0;
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            fetch_pc_reg    <= RESET_PC;
            ret_pc_reg      <= RESET_PC;
            outstanding_reg <= '0;
            drop_reg        <= '0;
            count_reg       <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            ret_pc_reg      <= ret_pc_next;
            outstanding_reg <= outstanding_next;
            drop_reg        <= drop_next;
            count_reg       <= count_next;
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
        end
    end

    // Per-entry storage; the head is read combinationally for show-ahead output.
    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            logic [INSTR_WIDTH-1:0] instr_reg;
            logic [ADDR_WIDTH-1:0]  pc_reg;

            always_ff @(posedge i_clk) begin
                if (push && (wr_ptr_reg == PW'(gi))) begin
                    instr_reg <= bus.i_imem_rdata;
                    pc_reg    <= ret_pc_reg;
                end
            end

            assign entry_instr[gi] = instr_reg;
            assign entry_pc[gi]    = pc_reg;
        end
    endgenerate

    assign bus.o_imem_raddr       = fetch_pc_reg;
    assign bus.o_imem_raddr_valid = req_valid;
    assign bus.o_imem_rdata_ready = 1'b1;
    assign bus.o_instr_valid      = ~fifo_empty;
    assign bus.o_instr            = entry_instr[rd_ptr_reg];
    assign bus.o_instr_pc         = entry_pc[rd_ptr_reg];

    // A response with nothing outstanding is a memory-side protocol violation.
    always_ff @(posedge i_clk) begin
        if (i_rstn && bus.i_imem_rdata_valid) begin
            a_rsp_has_credit: assert (outstanding_reg != '0);
        end
    end
endmodule
